// File: rtl/bus_mem_ctrl_pkg.sv
// Shared definitions for bus_mem_ctrl: address map, Memwrite codes, TX states.
// Also holds the byte-rotate helper used to align sub-word RAM reads.
package bus_mem_ctrl_pkg;

  localparam logic [31:0] UART_DATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_0004;
  localparam int          RAM_WORDS      = 1024;
  localparam int          RAM_IDX_W      = 10;

  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_WORD = 2'd1,
    WR_DMA  = 2'd2,
    WR_BYTE = 2'd3
  } wr_code_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Rotate right by whole bytes so the addressed byte lands in bits [7:0].
  function automatic logic [31:0] rotr_bytes(input logic [31:0] w, input logic [1:0] sh);
    logic [63:0] dbl;
    dbl = {w, w} >> {sh, 3'b000};
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; the FSM pops one byte per frame.
// A push into a full FIFO is dropped and flagged unless a pop frees a slot that cycle.
module uart_tx_fifo
  import bus_mem_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       push_drop,
  output logic       tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;

  logic pop, push_ok, baud_last;

  assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = (state_q == TX_IDLE) && !empty;
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && !push_ok;
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign busy      = (state_q != TX_IDLE);
  assign tx        = tx_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
  end

  // Frame sequencer; tx is registered so every bit holds for exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (!empty) begin
            state_q <= TX_START;
            shift_q <= fifo_mem[rd_ptr_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= TX_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        TX_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_mem_ctrl.sv
// Memory-mapped controller on a shared bidirectional bus: 4 KiB word RAM plus a
// UART transmitter with status register. Reads are combinational, zero wait states.
module bus_mem_ctrl
  import bus_mem_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  input  logic        Memread,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] Addr,
  output logic        tx
);

  wr_code_e              wr_code;
  logic                  ram_sel, data_sel, stat_sel, mapped;
  logic                  wr_word, wr_byte, wr_any, rd_en;
  logic [RAM_IDX_W-1:0]  ram_idx;
  logic [31:0]           ram_rd_word, rd_data;
  logic                  push, push_drop, fifo_full, fifo_empty, tx_busy;
  logic                  err_q, err_d, err_set, err_clr;

  assign wr_code  = wr_code_e'(Memwrite);
  assign ram_sel  = (Addr[31:12] == 20'd0);
  assign data_sel = (Addr == UART_DATA_ADDR);
  assign stat_sel = (Addr == UART_STAT_ADDR);
  assign mapped   = ram_sel || data_sel || stat_sel;
  assign wr_word  = (wr_code == WR_WORD);
  assign wr_byte  = (wr_code == WR_BYTE);
  assign wr_any   = wr_word || wr_byte;
  // A simultaneous write takes priority; the read is then ignored entirely.
  assign rd_en    = Memread && (wr_code == WR_NONE);
  assign ram_idx  = Addr[11:2];
  assign push     = wr_any && data_sel;

  // One byte-wide RAM per lane so a byte write touches only its own lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [RAM_WORDS];
    logic       lane_we;
    logic [7:0] lane_wdata;

    assign lane_we    = ram_sel && (wr_word || (wr_byte && (Addr[1:0] == 2'(gi))));
    assign lane_wdata = wr_word ? BUS[8*gi +: 8] : BUS[7:0];

    always_ff @(posedge clk) begin
      if (lane_we) lane_mem[ram_idx] <= lane_wdata;
    end

    assign ram_rd_word[8*gi +: 8] = lane_mem[ram_idx];
  end

  always_comb begin
    rd_data = '0;
    if (ram_sel)       rd_data = rotr_bytes(ram_rd_word, Addr[1:0]);
    else if (stat_sel) rd_data = {28'd0, err_q, tx_busy, fifo_empty, fifo_full};
  end

  assign BUS = rd_en ? rd_data : 32'bz;

  always_comb begin
    err_set = (wr_code == WR_DMA) || (wr_any && !mapped) || (rd_en && !mapped) || push_drop;
    err_clr = rd_en && stat_sel;
    err_d   = err_q;
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  uart_tx_fifo #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (BUS[7:0]),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .busy      (tx_busy),
    .push_drop (push_drop),
    .tx        (tx)
  );

endmodule
